bfm_result_writer: RTL and testbench

Downstream stage of `brute_force_matcher`: it collects per-query match results, packs four 32-bit results into each 128-bit beat, and buffers the beats. It then writes them to host memory as SAP master write bursts on the request, dataout and complete channels that `soc_it_bfm_top` services. It sits between the matcher core's result stream and the SAP master port.

---
 rtl/bfm_result_writer.sv | 215 +++++++++++++++++++++
 tb/tb_bfm_result_writer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfm_result_writer.sv
// Result writer: packs 32-bit match results four to a 128-bit beat, buffers them and writes SAP master bursts.
// Build macro BFM_RESULT_WRITER_THRESH_EN adds cfg_threshold, which drops results whose distance exceeds it.
//
//   state      | meaning
//   S_IDLE     | waiting for a full burst in the FIFO, or for a flush with beats left
//   S_REQ      | write request held until master_request_ack
//   S_DATA     | streaming len beats from the FIFO head
//   S_WAIT_CMP | waiting for master_request_complete, then advance offset/tag
module bfm_result_writer #(
    parameter int BURST_BEATS = 4,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic          sap_clk,
    input  logic          sap_rst,
    input  logic [63:0]   cfg_base_addr,
    input  logic          result_valid,
    output logic          result_ready,
    input  logic [31:0]   result_data,
    input  logic          result_last,
    output logic          master_request,
    input  logic          master_request_ack,
    input  logic          master_request_complete,
    output logic [3:0]    master_request_type,
    output logic [3:0]    master_request_tag,
    output logic [63:0]   master_request_local_address,
    output logic [35:0]   master_request_length,
    output logic          master_dataout_src_rdy,
    input  logic          master_dataout_dst_rdy,
    output logic [3:0]    master_dataout_tag,
    output logic [127:0]  master_dataout,
    output logic          done
`ifdef BFM_RESULT_WRITER_THRESH_EN
    ,
    input  logic [15:0]   cfg_threshold
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_BEATS);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_WAIT_CMP
    } state_t;

    state_t             state_q, state_d;
    logic [127:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [127:0]       pack_q;
    logic [1:0]         lane_q;
    logic               flush_q;
    logic               first_q;
    logic [63:0]        base_q;
    logic [63:0]        offset_q, offset_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic [3:0]         tag_q, tag_d;
    logic               done_q, done_d;

    logic               fifo_full, fifo_empty;
    logic               accept, keep, push, pop;
    logic [127:0]       beat_w;

    assign fifo_full    = (count_q == DEPTH_C);
    assign fifo_empty   = (count_q == '0);
    assign result_ready = !sap_rst && !fifo_full && !flush_q;
    assign accept       = result_valid && result_ready;

`ifdef BFM_RESULT_WRITER_THRESH_EN
    assign keep = accept && (result_data[15:0] <= cfg_threshold);
`else
    assign keep = accept;
`endif

    // A discarded last result still flushes whatever lanes are already packed.
    assign push = accept && ((keep && lane_q == 2'd3) ||
                             (result_last && (keep || lane_q != 2'd0)));

    always_comb begin
        beat_w = pack_q;
        if (keep) begin
            beat_w[{lane_q, 5'b00000} +: 32] = result_data;
        end
    end

    assign master_dataout_src_rdy = (state_q == S_DATA) && !fifo_empty;
    assign pop                    = master_dataout_src_rdy && master_dataout_dst_rdy;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        beats_d  = beats_q;
        offset_d = offset_q;
        tag_d    = tag_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q >= BURST_C || (flush_q && !fifo_empty)) begin
                    len_d   = (count_q >= BURST_C) ? BURST_C : count_q;
                    beats_d = len_d;
                    state_d = S_REQ;
                end else if (flush_q && lane_q == 2'd0) begin
                    // job ended with every result filtered out: nothing to write
                    done_d   = 1'b1;
                    offset_d = '0;
                end
            end
            S_REQ: begin
                if (master_request_ack) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (pop) begin
                    beats_d = beats_q - 1'b1;
                    if (beats_q == CNT_W'(1)) begin
                        state_d = S_WAIT_CMP;
                    end
                end
            end
            S_WAIT_CMP: begin
                if (master_request_complete) begin
                    offset_d = offset_q + 64'({len_q, 4'b0000});
                    tag_d    = tag_q + 4'd1;
                    state_d  = S_IDLE;
                    if (flush_q && fifo_empty && lane_q == 2'd0) begin
                        done_d   = 1'b1;
                        offset_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sap_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= beat_w;
        end
    end

    always_ff @(posedge sap_clk) begin
        if (sap_rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pack_q   <= '0;
            lane_q   <= '0;
            flush_q  <= 1'b0;
            first_q  <= 1'b1;
            base_q   <= '0;
            offset_q <= '0;
            len_q    <= '0;
            beats_q  <= '0;
            tag_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            len_q    <= len_d;
            beats_q  <= beats_d;
            tag_q    <= tag_d;
            done_q   <= done_d;

            if (accept) begin
                first_q <= 1'b0;
                if (first_q) begin
                    base_q <= cfg_base_addr;
                end
                if (result_last) begin
                    flush_q <= 1'b1;
                end
                if (push) begin
                    pack_q <= '0;
                    lane_q <= '0;
                end else if (keep) begin
                    pack_q <= beat_w;
                    lane_q <= lane_q + 2'd1;
                end
            end
            if (done_d) begin
                flush_q <= 1'b0;
                first_q <= 1'b1;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign master_request               = (state_q == S_REQ);
    assign master_request_type          = (state_q == S_REQ) ? 4'h1 : 4'h0;
    assign master_request_tag           = tag_q;
    assign master_request_local_address = base_q + offset_q;
    assign master_request_length        = 36'({len_q, 4'b0000});
    assign master_dataout_tag           = tag_q;
    assign master_dataout               = master_dataout_src_rdy ? mem_q[rd_ptr_q] : '0;
    assign done                         = done_q;

endmodule

// File: tb/tb_bfm_result_writer.sv
// Bench for bfm_result_writer: a host responder captures bursts, and a job-level reference model predicts beats and requests.
module tb_bfm_result_writer;
    localparam int BB = 4;
    localparam int FD = 16;

    logic          sap_clk = 1'b0;
    logic          sap_rst = 1'b1;
    logic [63:0]   cfg_base_addr = '0;
    logic          result_valid = 1'b0;
    logic          result_ready;
    logic [31:0]   result_data = '0;
    logic          result_last = 1'b0;
    logic          master_request;
    logic          master_request_ack = 1'b0;
    logic          master_request_complete = 1'b0;
    logic [3:0]    master_request_type;
    logic [3:0]    master_request_tag;
    logic [63:0]   master_request_local_address;
    logic [35:0]   master_request_length;
    logic          master_dataout_src_rdy;
    logic          master_dataout_dst_rdy = 1'b0;
    logic [3:0]    master_dataout_tag;
    logic [127:0]  master_dataout;
    logic          done;
`ifdef BFM_RESULT_WRITER_THRESH_EN
    logic [15:0]   cfg_threshold = 16'hFFFF;
`endif

    bfm_result_writer #(.BURST_BEATS(BB), .FIFO_DEPTH(FD)) dut (
        .sap_clk                      (sap_clk),
        .sap_rst                      (sap_rst),
        .cfg_base_addr                (cfg_base_addr),
        .result_valid                 (result_valid),
        .result_ready                 (result_ready),
        .result_data                  (result_data),
        .result_last                  (result_last),
        .master_request               (master_request),
        .master_request_ack           (master_request_ack),
        .master_request_complete      (master_request_complete),
        .master_request_type          (master_request_type),
        .master_request_tag           (master_request_tag),
        .master_request_local_address (master_request_local_address),
        .master_request_length        (master_request_length),
        .master_dataout_src_rdy       (master_dataout_src_rdy),
        .master_dataout_dst_rdy       (master_dataout_dst_rdy),
        .master_dataout_tag           (master_dataout_tag),
        .master_dataout               (master_dataout),
        .done                         (done)
`ifdef BFM_RESULT_WRITER_THRESH_EN
        ,
        .cfg_threshold                (cfg_threshold)
`endif
    );

    always #5 sap_clk = ~sap_clk;

    int tests = 0;
    int fails = 0;

    // captured host-side traffic
    logic [63:0]  cap_addr[$];
    logic [35:0]  cap_len[$];
    logic [3:0]   cap_tag[$];
    logic [3:0]   cap_type[$];
    logic [127:0] cap_beat[$];
    logic [3:0]   cap_btag[$];
    int           done_cnt = 0;
    bit           host_hold = 1'b0;
    bit           host_stall = 1'b0;

    // reference expectations
    logic [31:0]  res_q[$];
    bit           lst_q[$];
    logic [127:0] exp_beat[$];
    logic [3:0]   exp_btag[$];
    logic [63:0]  exp_addr[$];
    logic [35:0]  exp_len[$];
    logic [3:0]   exp_rtag[$];
    int           exp_tag = 0;
    int           job_done0 = 0;

    // SAP host: acks requests after a short random delay, drains beats, then signals completion
    initial begin
        int hst;
        int wait_n;
        int hbeats;
        hst = 0;
        wait_n = 0;
        hbeats = 0;
        forever begin
            @(negedge sap_clk);
            if (done) done_cnt++;
            if (sap_rst) begin
                hst = 0;
                master_request_ack = 1'b0;
                master_request_complete = 1'b0;
                master_dataout_dst_rdy = 1'b0;
            end else begin
                case (hst)
                    0: begin
                        master_request_complete = 1'b0;
                        if (master_request) begin
                            cap_addr.push_back(master_request_local_address);
                            cap_len.push_back(master_request_length);
                            cap_tag.push_back(master_request_tag);
                            cap_type.push_back(master_request_type);
                            hbeats = int'(master_request_length[35:4]);
                            wait_n = $urandom_range(0, 2);
                            hst = 1;
                        end
                    end
                    1: begin
                        if (wait_n == 0) begin
                            master_request_ack = 1'b1;
                            hst = 2;
                        end else begin
                            wait_n--;
                        end
                    end
                    2: begin
                        master_request_ack = 1'b0;
                        master_dataout_dst_rdy = !host_hold && (!host_stall || $urandom_range(0, 3) != 0);
                        if (master_dataout_src_rdy && master_dataout_dst_rdy) begin
                            cap_beat.push_back(master_dataout);
                            cap_btag.push_back(master_dataout_tag);
                            hbeats--;
                            if (hbeats <= 0) begin
                                wait_n = $urandom_range(0, 3);
                                hst = 3;
                            end
                        end
                    end
                    3: begin
                        master_dataout_dst_rdy = 1'b0;
                        if (wait_n == 0) begin
                            master_request_complete = 1'b1;
                            hst = 4;
                        end else begin
                            wait_n--;
                        end
                    end
                    default: begin
                        master_request_complete = 1'b0;
                        hst = 0;
                    end
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string ph);
        check({ph, "_ready"},  128'(result_ready), 128'(0));
        check({ph, "_req"},    128'(master_request), 128'(0));
        check({ph, "_type"},   128'(master_request_type), 128'(0));
        check({ph, "_tag"},    128'(master_request_tag), 128'(0));
        check({ph, "_addr"},   128'(master_request_local_address), 128'(0));
        check({ph, "_len"},    128'(master_request_length), 128'(0));
        check({ph, "_srcrdy"}, 128'(master_dataout_src_rdy), 128'(0));
        check({ph, "_dout"},   master_dataout, 128'(0));
        check({ph, "_dtag"},   128'(master_dataout_tag), 128'(0));
        check({ph, "_done"},   128'(done), 128'(0));
    endtask

    // Beats: four kept results per beat, lane 0 first; a last result closes a partial beat.
    // Requests: beats go out in chunks of BB, with the job's remainder as a short final burst.
    task automatic model(input logic [63:0] base);
        logic [127:0] cur;
        logic [63:0]  off;
        int k;
        int remaining;
        int l;
        bit keep;
        exp_beat.delete(); exp_btag.delete();
        exp_addr.delete(); exp_len.delete(); exp_rtag.delete();
        cur = '0;
        k = 0;
        foreach (res_q[i]) begin
            keep = 1'b1;
`ifdef BFM_RESULT_WRITER_THRESH_EN
            keep = (res_q[i][15:0] <= cfg_threshold);
`endif
            if (keep) begin
                cur[k*32 +: 32] = res_q[i];
                k++;
            end
            if (k == 4 || (lst_q[i] && k > 0)) begin
                exp_beat.push_back(cur);
                cur = '0;
                k = 0;
            end
        end
        remaining = exp_beat.size();
        off = '0;
        while (remaining > 0) begin
            l = (remaining < BB) ? remaining : BB;
            exp_addr.push_back(base + off);
            exp_len.push_back(36'(l * 16));
            exp_rtag.push_back(4'(exp_tag));
            repeat (l) exp_btag.push_back(4'(exp_tag));
            exp_tag = (exp_tag + 1) % 16;
            off = off + 64'(l * 16);
            remaining -= l;
        end
    endtask

    task automatic start_job(input logic [63:0] base);
        cap_addr.delete(); cap_len.delete(); cap_tag.delete(); cap_type.delete();
        cap_beat.delete(); cap_btag.delete();
        cfg_base_addr = base;
        job_done0 = done_cnt;
        model(base);
    endtask

    task automatic new_job(input int n, input logic [63:0] base);
        res_q.delete();
        lst_q.delete();
        for (int i = 0; i < n; i++) begin
            res_q.push_back($urandom);
            lst_q.push_back(i == n - 1);
        end
        start_job(base);
    endtask

    task automatic send(input logic [31:0] d, input bit l);
        int n;
        n = 0;
        result_valid = 1'b1;
        result_data = d;
        result_last = l;
        while (!result_ready && n < 400) begin
            @(negedge sap_clk);
            n++;
        end
        check("send_ready", 128'(result_ready), 128'(1));
        @(negedge sap_clk);
        result_valid = 1'b0;
        result_last = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            send(res_q[i], lst_q[i]);
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge sap_clk);
        end
    endtask

    task automatic finish_job(input string nm);
        int n;
        n = 0;
        while (done_cnt == job_done0 && n < 3000) begin
            @(negedge sap_clk);
            n++;
        end
        repeat (4) @(negedge sap_clk);
        check({nm, "_done_pulses"}, 128'(done_cnt - job_done0), 128'(1));
        check({nm, "_nreq"}, 128'(cap_addr.size()), 128'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", nm, i), 128'(cap_addr[i]), 128'(exp_addr[i]));
            check($sformatf("%s_len%0d", nm, i),  128'(cap_len[i]),  128'(exp_len[i]));
            check($sformatf("%s_tag%0d", nm, i),  128'(cap_tag[i]),  128'(exp_rtag[i]));
            check($sformatf("%s_type%0d", nm, i), 128'(cap_type[i]), 128'(1));
        end
        check({nm, "_nbeats"}, 128'(cap_beat.size()), 128'(exp_beat.size()));
        for (int i = 0; i < exp_beat.size() && i < cap_beat.size(); i++) begin
            check($sformatf("%s_beat%0d", nm, i),  cap_beat[i], exp_beat[i]);
            check($sformatf("%s_btag%0d", nm, i), 128'(cap_btag[i]), 128'(exp_btag[i]));
        end
    endtask

    initial begin
        int n;

        // reset state
        sap_rst = 1'b1;
        repeat (3) @(negedge sap_clk);
        check_reset_outputs("por");
        sap_rst = 1'b0;
        @(negedge sap_clk);
        check("por_ready_after", 128'(result_ready), 128'(1));

        // 16 results: one 64-byte burst, request two cycles after the completing accept
        new_job(16, 64'h1000);
        send_range(0, 16, 1'b0);
        check("lat_req_n1", 128'(master_request), 128'(0));
        @(negedge sap_clk);
        check("lat_req_n2", 128'(master_request), 128'(1));
        check("lat_addr", 128'(master_request_local_address), 128'(64'h1000));
        check("lat_len", 128'(master_request_length), 128'(64));
        check("lat_tag", 128'(master_request_tag), 128'(0));
        finish_job("j16");

        // 5 results: partial second beat, 32-byte burst
        new_job(5, 64'h1000);
        send_range(0, 5, 1'b1);
        finish_job("j5");

        // host holds dst_rdy low until the FIFO fills
        host_hold = 1'b1;
        new_job(66, 64'h1000);
        send_range(0, 64, 1'b0);
        check("full_ready_low", 128'(result_ready), 128'(0));
        result_valid = 1'b1;
        result_data = res_q[64];
        repeat (10) @(negedge sap_clk);
        check("full_ready_held", 128'(result_ready), 128'(0));
        check("full_no_pops", 128'(cap_beat.size()), 128'(0));
        check("full_head_valid", 128'(master_dataout_src_rdy), 128'(1));
        check("full_one_req", 128'(cap_addr.size()), 128'(1));
        host_hold = 1'b0;
        send_range(64, 66, 1'b0);
        finish_job("jfull");

        // address sum wraps modulo 2^64
        host_stall = 1'b1;
        new_job(32, 64'hFFFF_FFFF_FFFF_FFE0);
        send_range(0, 32, 1'b1);
        finish_job("jwrap");

        // randomized jobs with host stalls
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 40);
            new_job(n, {$urandom, $urandom});
            send_range(0, n, 1'b1);
            finish_job($sformatf("jrnd%0d", j));
        end
        host_stall = 1'b0;

        // 17 single-burst jobs: tag wraps, offset restarts each job
        for (int j = 0; j < 17; j++) begin
            n = $urandom_range(1, 16);
            new_job(n, {$urandom, $urandom[31:4], 4'h0});
            send_range(0, n, 1'b0);
            finish_job($sformatf("jb2b%0d", j));
        end

        // reset in the middle of a data phase
        new_job(16, 64'h3000);
        send_range(0, 16, 1'b0);
        n = 0;
        while (cap_beat.size() < 2 && n < 500) begin
            @(negedge sap_clk);
            n++;
        end
        check("rst_mid_two_beats", 128'(cap_beat.size() >= 2), 128'(1));
        sap_rst = 1'b1;
        @(negedge sap_clk);
        check_reset_outputs("rst_mid");
        @(negedge sap_clk);
        sap_rst = 1'b0;
        exp_tag = 0;
        @(negedge sap_clk);
        check("rst_mid_ready_after", 128'(result_ready), 128'(1));
        new_job(8, 64'h1000);
        send_range(0, 8, 1'b1);
        finish_job("jpost_rst");

`ifdef BFM_RESULT_WRITER_THRESH_EN
        // distance filter: 150 and 101 dropped, last still flushes
        cfg_threshold = 16'd100;
        res_q.delete();
        lst_q.delete();
        res_q.push_back({16'h0011, 16'd50});
        res_q.push_back({16'h0022, 16'd150});
        res_q.push_back({16'h0033, 16'd99});
        res_q.push_back({16'h0044, 16'd101});
        lst_q.push_back(1'b0); lst_q.push_back(1'b0); lst_q.push_back(1'b0); lst_q.push_back(1'b1);
        start_job(64'h5000);
        send_range(0, 4, 1'b0);
        finish_job("jthr");
        check("jthr_lanes", exp_beat.size() == 1 ? exp_beat[0] : 128'(0),
              {64'h0, 16'h0033, 16'd99, 16'h0011, 16'd50});

        // every result filtered: done with no request
        res_q.delete();
        lst_q.delete();
        res_q.push_back({16'h0055, 16'd200});
        res_q.push_back({16'h0066, 16'd300});
        lst_q.push_back(1'b0); lst_q.push_back(1'b1);
        start_job(64'h6000);
        send_range(0, 2, 1'b0);
        finish_job("jthr_none");
        cfg_threshold = 16'hFFFF;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
